// File: rtl/mdu_div_pkg.sv
// Shared CPU definitions used by the iterative divider: FSM state encoding
// and the ALU-control opcodes that select the divide/remainder operations.
package mdu_div_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } div_state_e;

   localparam logic [3:0] ALU_DIV  = 4'd8;
   localparam logic [3:0] ALU_DIVU = 4'd9;
   localparam logic [3:0] ALU_REM  = 4'd10;
   localparam logic [3:0] ALU_REMU = 4'd11;

endpackage

// File: rtl/mdu_div_core_step.sv
// One radix-2 restoring division step: shifts the next dividend bit into the
// partial remainder and subtracts the divisor when it fits.
module div_core_step #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] rem_i,
   input  logic             dvd_bit_i,
   input  logic [WIDTH-1:0] dvs_i,
   output logic [WIDTH-1:0] rem_o,
   output logic             q_bit_o
);

   logic [WIDTH:0] shifted;
   logic [WIDTH:0] diff;

   always_comb begin
      shifted = {rem_i, dvd_bit_i};
      diff    = shifted - {1'b0, dvs_i};
      // The partial remainder stays below the divisor, so a borrow shows up
      // in the extra top bit exactly when the divisor does not fit.
      q_bit_o = ~diff[WIDTH];
      rem_o   = q_bit_o ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
   end

endmodule

// File: rtl/mdu_div.sv
// Iterative restoring divider for DIV/DIVU: converts operands to magnitudes,
// runs WIDTH restoring steps, then applies the sign fix-up into the result.
module mdu_div
   import mdu_div_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               signed_div,
   input  logic [WIDTH-1:0]   dividend,
   input  logic [WIDTH-1:0]   divisor,
   input  logic               cancel,
   output logic               stall,
   output logic               valid,
   output logic [2*WIDTH-1:0] result,
   output logic               div_by_zero
);

   localparam int CNT_W = $clog2(WIDTH + 1);

   div_state_e         state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [WIDTH-1:0]   rem_q, rem_d;
   logic [WIDTH-1:0]   quo_q, quo_d;
   logic [WIDTH-1:0]   dvs_q, dvs_d;
   logic               neg_quo_q, neg_quo_d;
   logic               neg_rem_q, neg_rem_d;
   logic               zero_q, zero_d;
   logic [2*WIDTH-1:0] result_q, result_d;
   logic               dbz_q, dbz_d;

   logic [WIDTH-1:0]   step_rem, quo_next, quo_fix, rem_fix, dvd_mag, dvs_mag;
   logic               step_bit, dvd_neg, dvs_neg;

   div_core_step #(.WIDTH(WIDTH)) u_step (
      .rem_i     (rem_q),
      .dvd_bit_i (quo_q[WIDTH-1]),
      .dvs_i     (dvs_q),
      .rem_o     (step_rem),
      .q_bit_o   (step_bit)
   );

   // NOTE: combinational blocks use blocking '=' so later lines see the
   // values computed above them; only clocked blocks use '<='.
   always_comb begin
      dvd_neg  = signed_div & dividend[WIDTH-1];
      dvs_neg  = signed_div & divisor[WIDTH-1];
      dvd_mag  = dvd_neg ? -dividend : dividend;
      dvs_mag  = dvs_neg ? -divisor : divisor;
      quo_next = {quo_q[WIDTH-2:0], step_bit};
      // Divide-by-zero skips the quotient fix-up; the remainder fix-up then
      // reproduces the raw dividend from its magnitude.
      quo_fix  = zero_q ? '1 : (neg_quo_q ? -quo_next : quo_next);
      rem_fix  = neg_rem_q ? -step_rem : step_rem;
   end

   // NOTE: every signal is given its hold value first, so no path through
   // the case statement can leave one unassigned and infer a latch.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      rem_d     = rem_q;
      quo_d     = quo_q;
      dvs_d     = dvs_q;
      neg_quo_d = neg_quo_q;
      neg_rem_d = neg_rem_q;
      zero_d    = zero_q;
      result_d  = result_q;
      dbz_d     = dbz_q;
      case (state_q)
         IDLE: begin
            if (start && !cancel) begin
               state_d   = CALC;
               cnt_d     = '0;
               rem_d     = '0;
               quo_d     = dvd_mag;
               dvs_d     = dvs_mag;
               neg_quo_d = dvd_neg ^ dvs_neg;
               neg_rem_d = dvd_neg;
               zero_d    = (divisor == '0);
            end
         end
         CALC: begin
            if (cancel) begin
               state_d = IDLE;
            end else begin
               rem_d = step_rem;
               quo_d = quo_next;
               cnt_d = cnt_q + CNT_W'(1);
               if (cnt_q == CNT_W'(WIDTH - 1)) begin
                  state_d  = DONE;
                  result_d = {rem_fix, quo_fix};
                  dbz_d    = zero_q;
               end
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         rem_q     <= '0;
         quo_q     <= '0;
         dvs_q     <= '0;
         neg_quo_q <= 1'b0;
         neg_rem_q <= 1'b0;
         zero_q    <= 1'b0;
         result_q  <= '0;
         dbz_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         rem_q     <= rem_d;
         quo_q     <= quo_d;
         dvs_q     <= dvs_d;
         neg_quo_q <= neg_quo_d;
         neg_rem_q <= neg_rem_d;
         zero_q    <= zero_d;
         result_q  <= result_d;
         dbz_q     <= dbz_d;
      end
   end

   assign stall       = (start && state_q == IDLE && !cancel) || (state_q == CALC);
   assign valid       = (state_q == DONE) && !cancel;
   assign result      = result_q;
   assign div_by_zero = dbz_q;

endmodule

// File: doc/mdu_div.md
MDU_DIV -- requirements
Module: mdu_div

Interface
REQ-001 The block SHALL take parameter WIDTH, default 32, meaning operand/quotient/remainder width (legal range 8..64).
REQ-002 The block SHALL have input clk, 1 bit, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have input rst, 1 bit, asynchronous active-low reset.
REQ-004 The block SHALL have input start, 1 bit, request a divide; sampled only in IDLE.
REQ-005 The block SHALL have input signed_div, 1 bit: 1 = DIV (two's complement), 0 = DIVU; sampled with start.
REQ-006 The block SHALL have inputs dividend and divisor, WIDTH bits each, sampled with start.
REQ-007 The block SHALL have input cancel, 1 bit, abort an operation in progress (pipeline flush).
REQ-008 The block SHALL have output stall, 1 bit, combinational: (start & state==IDLE & ~cancel) | state==CALC.
REQ-009 The block SHALL have output valid, 1 bit, high for exactly one cycle when a result is ready.
REQ-010 The block SHALL have output result, 2*WIDTH bits, {remainder, quotient}, hi half to HI and lo half to LO.
REQ-011 The block SHALL have output div_by_zero, 1 bit, qualified by valid.

Function
REQ-012 The FSM SHALL have states IDLE, CALC, DONE; IDLE->CALC on start & ~cancel; CALC->DONE after WIDTH iterations; DONE->IDLE unconditionally.
REQ-013 Iteration SHALL be radix-2 restoring on operand magnitudes, one quotient bit per cycle, with an iteration counter of clog2(WIDTH+1) bits.
REQ-014 Latency SHALL be fixed: with start sampled at edge 0, valid is high in the cycle after edge WIDTH+1, independent of operand values.
REQ-015 In DONE, result SHALL be driven and valid=1; result and div_by_zero SHALL hold their values until the next accepted start.
REQ-016 With signed_div=1, the quotient SHALL truncate toward zero and the remainder SHALL take the sign of the dividend.
REQ-017 Most-negative / -1 SHALL give quotient = most-negative (wrap) and remainder = 0, with no flag.
REQ-018 Divisor = 0 SHALL give div_by_zero=1, quotient = all ones, and remainder = the raw dividend, with sign fix-up skipped and the same latency.
REQ-019 start while not in IDLE SHALL be ignored, with no queueing.
REQ-020 cancel in CALC or DONE SHALL force IDLE at the next edge; valid SHALL stay 0 in that cycle and result SHALL keep its previous value.
REQ-021 cancel and start together in IDLE SHALL leave the block in IDLE; cancel wins.
REQ-022 start in the same cycle as DONE SHALL be ignored; a back-to-back divide needs start in the following IDLE cycle.

Reset
REQ-023 rst low SHALL asynchronously force state=IDLE, the counter to 0, result to 0, div_by_zero to 0 and valid to 0.
REQ-024 Reset mid-CALC SHALL discard the operation, and no valid SHALL follow.
REQ-025 Release of rst SHALL be synchronised externally; the block SHALL NOT add a synchroniser.

Structure
REQ-026 The state encoding typedef (IDLE/CALC/DONE) and the divider ALU-control opcode constants SHALL live in the shared CPU definitions package.
REQ-027 One sub-module, div_core_step, SHALL be used: a combinational single restoring step (partial remainder, divisor) -> (next remainder, quotient bit).
REQ-028 Magnitude conversion and sign fix-up SHALL sit in mdu_div around the iterative core, and the total RTL SHALL be 120-400 lines.

Verification
REQ-029 A bench SHALL cover: WIDTH=32, DIVU 100/7 -> valid at cycle 33, result = {32'd2, 32'd14}, stall high in cycles 0-32.
REQ-030 A bench SHALL cover: WIDTH=32, DIV -7/2 -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF; DIV 7/-2 -> quotient 0xFFFFFFFD, remainder 1.
REQ-031 A bench SHALL cover: DIV 0x80000000/0xFFFFFFFF -> quotient 0x80000000, remainder 0, div_by_zero 0; DIVU 5/0 -> quotient 0xFFFFFFFF, remainder 5, div_by_zero 1.
REQ-032 A bench SHALL cover: cancel at cycle 10 of a divide -> IDLE at cycle 11, no valid, stall low, result unchanged; a fresh start at cycle 12 completes normally.
REQ-033 A bench SHALL cover: rst low mid-CALC -> state IDLE, valid 0, result 0 immediately without a clock; start asserted during CALC ignored.
REQ-034 A bench SHALL cover: WIDTH=8, DIVU 255/16 -> valid at cycle 9, result = {8'd15, 8'd15}.
